while_accum_seq: RTL and testbench
==================================

Name: while_accum_seq

Overview:
- Multi-cycle, handshaked successor to the combinational fixed-count while-loop entity.
- Runs a runtime-programmable number of increment iterations on an internal accumulator, one per clock, then computes XOUT = W'(temp * A) - B.
- Sits between a valid/ready producer and a valid/ready consumer in datapath test designs.
- Widths, count range and initial accumulator value are parametrised.

Parameters:
- W, 8, data width of A, B, XOUT and the accumulator.
- CW, 4, width of the COUNT input; max iterations 2^CW-1.
- INIT, 1, accumulator start value, truncated to W bits.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_VALID  input  1  operand set valid.
- IN_READY  output  1  block can accept operands.
- A  input  W  multiplicand operand.
- B  input  W  subtrahend operand.
- COUNT  input  CW  number of loop iterations.
- XOUT  output  W  result, registered.
- OUT_VALID  output  1  XOUT valid.
- OUT_READY  input  1  consumer accepts XOUT.
- BUSY  output  1  high whenever state != IDLE.

Behaviour:
- Reset (RST_N low, asynchronous, any state): state=IDLE, XOUT=0, OUT_VALID=0, internal temp/iter/A/B registers=0. An in-flight operation is discarded and no output is produced. IN_READY=1 and BUSY=0 while in reset.
- States: IDLE, LOOP, CALC, DONE (one-hot or binary, implementer's choice).
- IDLE:
  - IN_READY=1.
  - On IN_VALID&IN_READY: latch A, B, COUNT; temp<=INIT; iter<=COUNT.
  - Next state is LOOP if COUNT!=0, else CALC.
- LOOP:
  - Each cycle: temp<=temp+1 (mod 2^W), iter<=iter-1.
  - When iter==1, go to CALC. Exactly COUNT cycles are spent in LOOP.
- CALC: XOUT<=(temp*A)[W-1:0] - B_latched, mod 2^W. Then OUT_VALID<=1 and go to DONE.
- DONE:
  - XOUT and OUT_VALID held stable until OUT_READY=1.
  - On that edge: OUT_VALID<=0, go to IDLE. XOUT keeps its last value.
- IN_READY=0 in LOOP, CALC and DONE. Inputs are ignored outside IDLE; operand changes after acceptance have no effect.
- Latency: OUT_VALID rises COUNT+1 cycles after the accept edge (COUNT=0 gives 1 cycle).
- Throughput: at most one operation per COUNT+3 cycles when OUT_READY is tied high. There is a mandatory IDLE cycle between a result handshake and the next accept.
- Multiply: full 2W-bit product, low W bits kept. Subtraction wraps (unsigned) unless the optional feature is enabled.
- OUT_READY asserted while OUT_VALID=0 is ignored.
- IN_VALID may be held across a busy period. It is accepted on the first IDLE cycle.

Optional Feature:
- Macro: WHILE_ACCUM_SAT_EN.
- Defined: the CALC subtraction saturates at 0 when B_latched > truncated product, giving XOUT=0.
- Not defined: unsigned wrap-around as above.
- No port differences either way.

Test Plan:
- W=8, INIT=1: A=3, B=2, COUNT=4 accepted, OUT_READY=1 -> OUT_VALID high exactly 5 cycles after accept, XOUT=13, BUSY high for 6 cycles.
- A=200, B=0, COUNT=4 -> product 1000 truncated, XOUT=232.
- A=1, B=10, COUNT=0 -> OUT_VALID 1 cycle after accept. XOUT=247 without WHILE_ACCUM_SAT_EN, XOUT=0 with it.
- Backpressure:
  - A=2, B=1, COUNT=3 with OUT_READY=0 for 10 cycles -> XOUT=7 and OUT_VALID held stable, IN_READY=0 throughout.
  - Raise OUT_READY -> OUT_VALID falls the next edge.
  - A second IN_VALID held high is accepted only one cycle after the handshake.
- RST_N pulsed low mid-LOOP (A=5, B=0, COUNT=15, after 6 cycles) -> immediate IDLE, OUT_VALID=0, XOUT=0, no result emitted. A new op A=1, B=0, COUNT=15 afterwards gives XOUT=16.
- Operand hold: change A/B/COUNT during LOOP -> result uses the latched values only.

Source files
------------

// File: rtl/while_accum_seq.sv
// while_accum_seq: handshaked multi-cycle accumulator loop.
// Accepts A, B and COUNT on an IN_VALID/IN_READY handshake, increments an
// internal accumulator (starting at INIT) once per clock for COUNT cycles,
// then produces XOUT = (temp * A)[W-1:0] - B on an OUT_VALID/OUT_READY
// handshake.
// Optional build macro WHILE_ACCUM_SAT_EN: when defined, the final
// subtraction saturates at zero instead of wrapping.
module while_accum_seq #(
   parameter int W    = 8,
   parameter int CW   = 4,
   parameter int INIT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   input  logic [CW-1:0] count,
   output logic [W-1:0]  xout,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOOP = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [W-1:0]  INIT_W = W'(INIT);
   localparam logic [CW-1:0] ITER_ONE = CW'(1);
   localparam logic [W-1:0]  TEMP_ONE = W'(1);

   state_t        state_r;
   state_t        state_nxt_s;
   logic          accept_s;
   logic [W-1:0]  a_r;
   logic [W-1:0]  b_r;
   logic [W-1:0]  temp_r;
   logic [CW-1:0] iter_r;
   logic [W-1:0]  xout_r;
   logic          out_valid_r;
   logic          in_ready_r;
   logic          busy_r;

   // Final result: only the low W bits of the 2W-bit product are kept,
   // and those bits do not depend on the upper half, so a W-bit multiply
   // yields the same value.
   function automatic logic [W-1:0] calc_result(
      input logic [W-1:0] t,
      input logic [W-1:0] m,
      input logic [W-1:0] s
   );
      logic [W-1:0] p;
      p = t * m;
`ifdef WHILE_ACCUM_SAT_EN
      if (s > p) begin
         calc_result = {W{1'b0}};
      end else begin
         calc_result = p - s;
      end
`else
      calc_result = p - s;
`endif
   endfunction

   // Next-state logic and operand-accept decode.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               accept_s = 1'b1;
               if (count != {CW{1'b0}}) begin
                  state_nxt_s = LOOP;
               end else begin
                  state_nxt_s = CALC;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOOP: begin
            if (iter_r == ITER_ONE) begin
               state_nxt_s = CALC;
            end else begin
               state_nxt_s = LOOP;
            end
         end
         CALC: begin
            state_nxt_s = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Status outputs registered from the next state so they track the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r <= 1'b1;
         busy_r     <= 1'b0;
      end else begin
         in_ready_r <= (state_nxt_s == IDLE);
         busy_r     <= (state_nxt_s != IDLE);
      end
   end

   // Datapath: operand latch, loop accumulator, result and output valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r         <= {W{1'b0}};
         b_r         <= {W{1'b0}};
         temp_r      <= {W{1'b0}};
         iter_r      <= {CW{1'b0}};
         xout_r      <= {W{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  a_r    <= a;
                  b_r    <= b;
                  temp_r <= INIT_W;
                  iter_r <= count;
               end
            end
            LOOP: begin
               temp_r <= temp_r + TEMP_ONE;
               iter_r <= iter_r - ITER_ONE;
            end
            CALC: begin
               xout_r      <= calc_result(temp_r, a_r, b_r);
               out_valid_r <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign busy      = busy_r;
   assign xout      = xout_r;
   assign out_valid = out_valid_r;

endmodule

// File: tb/tb_while_accum_seq.sv
// Directed self-checking bench for while_accum_seq (W=8, CW=4, INIT=1).
module tb_while_accum_seq;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] count;
   logic [7:0] xout;
   logic       out_valid;
   logic       out_ready;
   logic       busy;

   int checks_cnt;
   int errors_cnt;

   while_accum_seq #(.W(8), .CW(4), .INIT(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .count     (count),
      .xout      (xout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation with OUT_READY high; operands are scrambled right
   // after acceptance so the result must come from the latched values.
   task automatic do_op(input logic [7:0] a_v, input logic [7:0] b_v,
                        input logic [3:0] c_v, input logic [7:0] exp_x,
                        input string tag);
      int lat;
      int busy_cnt;
      check_val({tag, " in_ready before"}, in_ready, 1);
      a = a_v; b = b_v; count = c_v; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      a = ~a_v; b = ~b_v; count = ~c_v;
      check_val({tag, " in_ready after accept"}, in_ready, 0);
      lat = 0;
      busy_cnt = busy ? 1 : 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
         if (busy) busy_cnt++;
      end
      check_val({tag, " latency"}, lat, c_v + 1);
      check_val({tag, " xout"}, xout, exp_x);
      tick();
      if (busy) busy_cnt++;
      check_val({tag, " out_valid drop"}, out_valid, 0);
      check_val({tag, " busy cycles"}, busy_cnt, c_v + 2);
   endtask

   initial begin
      int seen;
      checks_cnt = 0;
      errors_cnt = 0;
      in_valid = 1'b0; a = 8'd0; b = 8'd0; count = 4'd0; out_ready = 1'b0;
      rst_n = 1'b0;
      #12;
      check_val("reset in_ready", in_ready, 1);
      check_val("reset busy", busy, 0);
      check_val("reset out_valid", out_valid, 0);
      check_val("reset xout", xout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      do_op(8'd3, 8'd2, 4'd4, 8'd13, "basic");
      do_op(8'd200, 8'd0, 4'd4, 8'd232, "trunc");
`ifdef WHILE_ACCUM_SAT_EN
      do_op(8'd1, 8'd10, 4'd0, 8'd0, "count0");
`else
      do_op(8'd1, 8'd10, 4'd0, 8'd247, "count0");
`endif

      // Backpressure with a second request held on IN_VALID.
      a = 8'd2; b = 8'd1; count = 4'd3; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      a = 8'd4; b = 8'd0; count = 4'd1;
      seen = 0;
      while (!out_valid && seen < 40) begin
         tick();
         seen++;
      end
      check_val("bp latency", seen, 4);
      for (int i = 0; i < 10; i++) begin
         check_val("bp out_valid hold", out_valid, 1);
         check_val("bp xout hold", xout, 7);
         check_val("bp in_ready low", in_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check_val("bp out_valid fall", out_valid, 0);
      check_val("bp idle in_ready", in_ready, 1);
      check_val("bp idle busy", busy, 0);
      tick();
      in_valid = 1'b0;
      check_val("bp second accepted", busy, 1);
      seen = 0;
      while (!out_valid && seen < 40) begin
         tick();
         seen++;
      end
      check_val("bp second latency", seen, 2);
      check_val("bp second xout", xout, 8);
      tick();

      // Reset in the middle of a long loop.
      a = 8'd5; b = 8'd0; count = 4'd15; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (6) tick();
      check_val("mid busy before reset", busy, 1);
      rst_n = 1'b0;
      #2;
      check_val("mid reset out_valid", out_valid, 0);
      check_val("mid reset xout", xout, 0);
      check_val("mid reset busy", busy, 0);
      check_val("mid reset in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid) seen++;
      end
      check_val("no result after reset", seen, 0);
      do_op(8'd1, 8'd0, 4'd15, 8'd16, "after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
